// File: rtl/halt_monitor_pkg.sv
// Shared types and constants for the halt monitor beside the IF stage.
package halt_monitor_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR          = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       value <= '0;
    else if (clear)                   value <= '0;
    else if (enable && (value != '1)) value <= value + WIDTH'(1);
  end
endmodule

// File: rtl/halt_monitor.sv
// Detects the halt word at fetch, drains older instructions, then raises
// end_program and freezes run statistics; optional cycle watchdog.
module halt_monitor
  import halt_monitor_pkg::*;
#(
  parameter int          PIPE_DEPTH = 5,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
  parameter int          MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  input  logic             stall,
  input  logic             flush,
  input  logic             wb_valid,
  output logic             halt_fetch,
  output logic             end_program,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] retired_count,
  output logic [31:0]      halt_pc
);
  localparam int             DW         = $clog2(PIPE_DEPTH) + 1;
  localparam logic [DW-1:0]  DRAIN_INIT = DW'(PIPE_DEPTH - 1);

  state_t        state;
  logic [DW-1:0] drain_cnt;
  logic          detect, wd_hit, running;

  assign running    = (state != DONE);
  assign detect     = (state == RUN) && if_valid && !stall && !flush && (if_instr == HALT_INSTR);
  assign wd_hit     = (MAX_CYCLES != 0) && running && (cycle_count == CNT_W'(MAX_CYCLES - 1));
  assign halt_fetch = detect || (state != RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= '0;
      halt_pc     <= '0;
      end_program <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (wd_hit) begin
            state       <= DONE;
            end_program <= 1'b1;
            timeout     <= 1'b1;
          end else if (detect) begin
            state     <= DRAIN;
            halt_pc   <= if_pc;
            drain_cnt <= DRAIN_INIT;
          end
        end
        DRAIN: begin
          // A flush while the halt word still sits in ID means it was wrong-path.
          if (wd_hit) begin
            state       <= DONE;
            end_program <= 1'b1;
            timeout     <= 1'b1;
          end else if (flush && (drain_cnt == DRAIN_INIT)) begin
            state <= RUN;
          end else if (!stall) begin
            drain_cnt <= drain_cnt - DW'(1);
            if (drain_cnt == DW'(1)) begin
              state       <= DONE;
              end_program <= 1'b1;
            end
          end
        end
        DONE:    ;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (running),
    .clear  (1'b0),
    .value  (cycle_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retired_cnt (
    .clk    (clk),
    .reset  (reset),
    .enable (running && wb_valid),
    .clear  (1'b0),
    .value  (retired_count)
  );
endmodule

// File: tb/tb_halt_monitor.sv
// Scoreboard bench for halt_monitor: one DUT without watchdog, one with MAX_CYCLES=20.
module tb_halt_monitor;
  import halt_monitor_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_valid = 1'b0, stall = 1'b0, flush = 1'b0, wb_valid = 1'b0;
  logic [31:0] if_instr = '0, if_pc = '0;

  logic        hf0, ep0, to0, hf1, ep1, to1;
  logic [31:0] cc0, rc0, hpc0, cc1, rc1, hpc1;

  halt_monitor u_dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .stall(stall), .flush(flush), .wb_valid(wb_valid), .halt_fetch(hf0), .end_program(ep0),
    .timeout(to0), .cycle_count(cc0), .retired_count(rc0), .halt_pc(hpc0));

  halt_monitor #(.MAX_CYCLES(20)) u_wd (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .stall(stall), .flush(flush), .wb_valid(wb_valid), .halt_fetch(hf1), .end_program(ep1),
    .timeout(to1), .cycle_count(cc1), .retired_count(rc1), .halt_pc(hpc1));

  always #5 clk = ~clk;

  typedef struct {
    int          done_cyc;
    logic [31:0] cc, rc, hpc;
    logic        to, ep, hf;
  } res_t;

  res_t exp_q[$], obs_q[$];
  res_t rst_snap, last_snap;
  logic hf_trace [0:63];
  int   halt_cyc, halt2_cyc, stall_lo, stall_hi, flush_cyc, wb_lo, wb_hi;
  int   n_cmp = 0, n_err = 0;

  function automatic void cfg_default();
    halt_cyc = 6; halt2_cyc = -1; stall_lo = -1; stall_hi = -1;
    flush_cyc = -1; wb_lo = 4; wb_hi = 9;
  endfunction

  // Reference model: retirements seen before the DONE cycle all count.
  function automatic int exp_retired(int done);
    int r = 0;
    for (int i = 0; i < done; i++) if (i >= wb_lo && i <= wb_hi) r++;
    return r;
  endfunction

  function automatic res_t snap(bit wd, int n);
    res_t s;
    s.done_cyc = n;
    s.cc  = wd ? cc1  : cc0;
    s.rc  = wd ? rc1  : rc0;
    s.hpc = wd ? hpc1 : hpc0;
    s.to  = wd ? to1  : to0;
    s.ep  = wd ? ep1  : ep0;
    s.hf  = wd ? hf1  : hf0;
    return s;
  endfunction

  task automatic push_exp(input int done, input logic [31:0] hpc, input logic to);
    res_t e;
    e.done_cyc = done; e.cc = done; e.rc = exp_retired(done);
    e.hpc = hpc; e.to = to; e.ep = 1'b1; e.hf = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int n);
    if_valid = 1'b1;
    if_pc    = n * 4;
    if_instr = NOP_INSTR;
    if (n == halt_cyc)  begin if_instr = 32'h0; if_pc = 32'h18; end
    if (n == halt2_cyc) begin if_instr = 32'h0; if_pc = 32'h40; end
    stall    = (n >= stall_lo) && (n <= stall_hi);
    flush    = (n == flush_cyc);
    wb_valid = (n >= wb_lo) && (n <= wb_hi);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_valid = 1'b0; stall = 1'b0; flush = 1'b0; wb_valid = 1'b0;
    if_instr = '0; if_pc = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // Runs a bounded number of cycles; pushes the observed result on first end_program.
  task automatic run_cycles(input int ncyc, input bit wd, input int rst_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) hf_trace[i] = 1'bx;
    for (int n = 0; n < ncyc; n++) begin
      drive(n);
      if (n == rst_cyc) begin
        #1 reset = 1'b0;
        #1 rst_snap = snap(wd, n);
        return;
      end
      #3;
      hf_trace[n] = wd ? hf1 : hf0;
      if (!seen && (wd ? ep1 : ep0)) begin
        seen = 1'b1;
        obs_q.push_back(snap(wd, n));
      end
      last_snap = snap(wd, n);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #2;
    n_cmp++; if ({ep0, hf0, to0} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {ep0, hf0, to0}); end
    n_cmp++; if ({cc0, rc0, hpc0} !== 96'h0) begin n_err++; $display("FAIL reset_regs: got %h want 0", {cc0, rc0, hpc0}); end
    n_cmp++; if ({ep1, hf1, to1, cc1} !== 35'h0) begin n_err++; $display("FAIL reset_wd: got %h want 0", {ep1, hf1, to1, cc1}); end
  endtask

  task automatic test_basic();
    res_t e, o;
    cfg_default();
    do_reset();
    push_exp(11, 32'h18, 1'b0);
    run_cycles(24, 1'b0, -1);
    n_cmp++; if (hf_trace[5] !== 1'b0) begin n_err++; $display("FAIL basic hf5: got %b want 0", hf_trace[5]); end
    n_cmp++; if (hf_trace[6] !== 1'b1) begin n_err++; $display("FAIL basic hf6: got %b want 1", hf_trace[6]); end
    n_cmp++; if (last_snap.cc !== 32'd11) begin n_err++; $display("FAIL basic frozen_cc: got %0d want 11", last_snap.cc); end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL basic done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL basic done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.cc !== e.cc) begin n_err++; $display("FAIL basic cycle_count: got %0d want %0d", o.cc, e.cc); end
      n_cmp++; if (o.rc !== e.rc) begin n_err++; $display("FAIL basic retired: got %0d want %0d", o.rc, e.rc); end
      n_cmp++; if (o.hpc !== e.hpc) begin n_err++; $display("FAIL basic halt_pc: got %h want %h", o.hpc, e.hpc); end
      n_cmp++; if (o.to !== e.to) begin n_err++; $display("FAIL basic timeout: got %b want %b", o.to, e.to); end
    end
  endtask

  task automatic test_stall();
    res_t e, o;
    cfg_default();
    stall_lo = 8; stall_hi = 9;
    do_reset();
    push_exp(13, 32'h18, 1'b0);
    run_cycles(24, 1'b0, -1);
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL stall done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL stall done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.cc !== e.cc) begin n_err++; $display("FAIL stall cycle_count: got %0d want %0d", o.cc, e.cc); end
      n_cmp++; if (o.rc !== e.rc) begin n_err++; $display("FAIL stall retired: got %0d want %0d", o.rc, e.rc); end
    end
  endtask

  task automatic test_wrong_path();
    res_t e, o;
    cfg_default();
    flush_cyc = 7; halt2_cyc = 12;
    do_reset();
    push_exp(17, 32'h40, 1'b0);
    run_cycles(24, 1'b0, -1);
    n_cmp++; if (hf_trace[7] !== 1'b1) begin n_err++; $display("FAIL wrong_path hf7: got %b want 1", hf_trace[7]); end
    n_cmp++; if (hf_trace[8] !== 1'b0) begin n_err++; $display("FAIL wrong_path hf8: got %b want 0", hf_trace[8]); end
    n_cmp++; if (hf_trace[12] !== 1'b1) begin n_err++; $display("FAIL wrong_path hf12: got %b want 1", hf_trace[12]); end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL wrong_path done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL wrong_path done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.hpc !== e.hpc) begin n_err++; $display("FAIL wrong_path halt_pc: got %h want %h", o.hpc, e.hpc); end
      n_cmp++; if (o.cc !== e.cc) begin n_err++; $display("FAIL wrong_path cycle_count: got %0d want %0d", o.cc, e.cc); end
    end
  endtask

  task automatic test_flush_same_cycle();
    res_t e, o;
    cfg_default();
    flush_cyc = 6; halt2_cyc = 10;
    do_reset();
    push_exp(15, 32'h40, 1'b0);
    run_cycles(24, 1'b0, -1);
    n_cmp++; if (hf_trace[6] !== 1'b0) begin n_err++; $display("FAIL flush_same hf6: got %b want 0", hf_trace[6]); end
    n_cmp++; if (hf_trace[7] !== 1'b0) begin n_err++; $display("FAIL flush_same hf7: got %b want 0", hf_trace[7]); end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL flush_same done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL flush_same done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.hpc !== e.hpc) begin n_err++; $display("FAIL flush_same halt_pc: got %h want %h", o.hpc, e.hpc); end
    end
  endtask

  task automatic test_watchdog();
    res_t e, o;
    cfg_default();
    halt_cyc = -1;
    do_reset();
    push_exp(20, 32'h0, 1'b1);
    run_cycles(26, 1'b1, -1);
    n_cmp++; if (ep0 !== 1'b0) begin n_err++; $display("FAIL watchdog no_wd_dut_ep: got %b want 0", ep0); end
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL watchdog done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL watchdog done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.cc !== e.cc) begin n_err++; $display("FAIL watchdog cycle_count: got %0d want %0d", o.cc, e.cc); end
      n_cmp++; if (o.to !== e.to) begin n_err++; $display("FAIL watchdog timeout: got %b want %b", o.to, e.to); end
      n_cmp++; if (o.rc !== e.rc) begin n_err++; $display("FAIL watchdog retired: got %0d want %0d", o.rc, e.rc); end
    end
  endtask

  task automatic test_async_reset();
    res_t e, o;
    cfg_default();
    do_reset();
    run_cycles(24, 1'b0, 9);
    n_cmp++; if (hf_trace[8] !== 1'b1) begin n_err++; $display("FAIL async pre_hf8: got %b want 1", hf_trace[8]); end
    n_cmp++; if ({rst_snap.ep, rst_snap.hf, rst_snap.to} !== 3'b000) begin n_err++; $display("FAIL async flags: got %b want 000", {rst_snap.ep, rst_snap.hf, rst_snap.to}); end
    n_cmp++; if ({rst_snap.cc, rst_snap.rc, rst_snap.hpc} !== 96'h0) begin n_err++; $display("FAIL async regs: got %h want 0", {rst_snap.cc, rst_snap.rc, rst_snap.hpc}); end
    do_reset();
    push_exp(11, 32'h18, 1'b0);
    run_cycles(24, 1'b0, -1);
    e = exp_q.pop_front();
    if (obs_q.size() == 0) begin n_cmp++; n_err++; $display("FAIL async done: no end_program within budget"); end
    else begin
      o = obs_q.pop_front();
      n_cmp++; if (o.done_cyc !== e.done_cyc) begin n_err++; $display("FAIL async done_cyc: got %0d want %0d", o.done_cyc, e.done_cyc); end
      n_cmp++; if (o.cc !== e.cc) begin n_err++; $display("FAIL async cycle_count: got %0d want %0d", o.cc, e.cc); end
      n_cmp++; if (o.rc !== e.rc) begin n_err++; $display("FAIL async retired: got %0d want %0d", o.rc, e.rc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrong_path();
    test_flush_same_cycle();
    test_watchdog();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
